decoder_stage: RTL and testbench
================================

// Module: decoder_stage
// PURPOSE
//  Registered RV32I/RV64I instruction decode stage with a valid/ready handshake on both sides.
//  Decodes each accepted instruction (fields, sign-extended immediate, illegal-opcode flag) and
//  queues the result with its PC in a small FIFO, decoupling fetch from execute.
//  Sits between the fetch unit and the ALU/control FSM; flushed on branch/trap redirect.
// PARAMETERS
//  XLEN        32  immediate/PC width; 32 or 64 only; immediates sign-extend to XLEN
//  DEPTH       2   FIFO entries; power of two, >=2
//  CHK_ILLEGAL 1   1: O_illegal computed per rules below; 0: O_illegal tied 0
// PORTS
//  I_clk        in   1        clock, all state on rising edge
//  I_reset      in   1        asynchronous, active-high reset
//  I_flush      in   1        synchronous discard of all queued entries
//  I_in_valid   in   1        I_instr/I_pc valid
//  O_in_ready   out  1        stage can accept (FIFO not full)
//  I_instr      in   32       raw instruction word
//  I_pc         in   XLEN     instruction address
//  O_out_valid  out  1        head entry valid (FIFO not empty)
//  I_out_ready  in   1        consumer takes head entry
//  O_rs1/O_rs2/O_rd out 5 ea  register fields [19:15]/[24:20]/[11:7]
//  O_opcode     out  5        instr[6:2]
//  O_funct3     out  3        instr[14:12]
//  O_funct7     out  7        instr[31:25]
//  O_imm        out  XLEN     decoded immediate
//  O_pc         out  XLEN     PC of head entry
//  O_illegal    out  1        head instruction has unsupported encoding
//  O_count      out  clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset: FIFO empty, pointers 0, O_count=0, O_out_valid=0, O_in_ready=1; all data outputs 0.
//  - Push when I_in_valid&&O_in_ready; pop when O_out_valid&&I_out_ready. O_in_ready = (count!=DEPTH),
//    independent of I_out_ready (no combinational ready path). Push and pop same cycle: count unchanged.
//  - Latency: accepted instr appears at head earliest next cycle; no fall-through. Outputs come from
//    FIFO storage; data outputs hold last head value (stale) when empty, must not be used.
//  - Pointers wrap modulo DEPTH; order strictly FIFO.
//  - I_flush: next edge count=0, pointers 0; push in flush cycle is dropped; overrides pop.
//  - Decode done combinationally on I_instr before write; stored fields = decoded values.
//  - Immediate by opcode (instr[6:2]), all sign-extended from instr[31] to XLEN:
//    STORE 01000: {instr[31:25],instr[11:7]}; BRANCH 11000: {[31],[7],[30:25],[11:8],0};
//    LUI 01101/AUIPC 00101: {instr[31:12],12'b0} then sign-extend (RV64 semantics);
//    JAL 11011: {[31],[19:12],[20],[30:21],0}; all others: instr[31:20] (I-type, R-type don't-care).
//  - Illegal (CHK_ILLEGAL=1): instr[1:0]!=2'b11, or opcode not in {LOAD 00000, MISC-MEM 00011,
//    OP-IMM 00100, AUIPC 00101, STORE 01000, OP 01100, LUI 01101, BRANCH 11000, JALR 11001,
//    JAL 11011, SYSTEM 11100}; additionally OP-IMM-32 00110/OP-32 01110 legal only when XLEN=64.
//    Illegal instructions are queued like any other (flag travels with entry); stage never stalls on them.
//  - Reset mid-operation: immediate return to reset state, queued entries lost.
// TESTING
//  1 XLEN=32: push 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, rd=1, rs1=0, opcode=00100, imm=0x00000005, illegal=0.
//  2 Push 0xFE20AE23 (sw x2,-4(x1)) -> imm=0xFFFFFFFC, rs1=1, rs2=2, funct3=010; 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC.
//  3 XLEN=64: push 0x800002B7 (lui x5,0x80000) -> imm=0xFFFFFFFF80000000, rd=5; 0x0000001B legal, XLEN=32 same word illegal=1.
//  4 I_out_ready=0, DEPTH=2: push 3 back-to-back -> 2 accepted, O_in_ready=0 after 2nd, count=2; then out_ready=1 pops in order with matching O_pc.
//  5 Full FIFO, simultaneous push+pop -> push refused (in_ready=0), count 2->1; half-full push+pop -> count stays 1, order kept.
//  6 count=2 plus I_flush with I_in_valid=1 -> next cycle count=0, out_valid=0; instr 0x00000000 pushed later -> illegal=1; async reset mid-stream clears count without clock edge.

Source files
------------

// File: rtl/decoder_stage.sv
// decoder_stage: RV32I/RV64I decode stage. Each accepted instruction is decoded
// combinationally, then written with its PC into a small FIFO. The FIFO head drives
// the outputs, so fetch and execute stay decoupled with no combinational ready path.
module decoder_stage #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 2,
  parameter int CHK_ILLEGAL = 1
) (
  input  logic                     I_clk,
  input  logic                     I_reset,
  input  logic                     I_flush,
  input  logic                     I_in_valid,
  output logic                     O_in_ready,
  input  logic [31:0]              I_instr,
  input  logic [XLEN-1:0]          I_pc,
  output logic                     O_out_valid,
  input  logic                     I_out_ready,
  output logic [4:0]               O_rs1,
  output logic [4:0]               O_rs2,
  output logic [4:0]               O_rd,
  output logic [4:0]               O_opcode,
  output logic [2:0]               O_funct3,
  output logic [6:0]               O_funct7,
  output logic [XLEN-1:0]          O_imm,
  output logic [XLEN-1:0]          O_pc,
  output logic                     O_illegal,
  output logic [$clog2(DEPTH):0]   O_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [4:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  // Immediate extraction; every format is built as a signed 32-bit value first and
  // then widened, which gives RV64 semantics for LUI/AUIPC as well.
  function automatic logic signed [XLEN-1:0] decode_imm(input logic [31:0] instr);
    logic signed [31:0] raw;
    case (instr[6:2])
      5'b01000:          raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      5'b11000:          raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
      5'b01101, 5'b00101: raw = {instr[31:12], 12'b0};
      5'b11011:          raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
      default:           raw = {{20{instr[31]}}, instr[31:20]};
    endcase
    decode_imm = XLEN'(raw);
  endfunction

  // Unsupported-encoding check; the *-32 opcodes only exist on RV64.
  function automatic logic decode_illegal(input logic [31:0] instr);
    logic bad;
    bad = 1'b0;
    if (CHK_ILLEGAL != 0) begin
      if (instr[1:0] != 2'b11) bad = 1'b1;
      case (instr[6:2])
        5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
        5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: ;
        5'b00110, 5'b01110: if (XLEN != 64) bad = 1'b1;
        default:            bad = 1'b1;
      endcase
    end
    decode_illegal = bad;
  endfunction

  entry_t         dec_p0;
  entry_t         mem_p1 [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;
  entry_t         head;

  // Stage 0: decode the incoming word ahead of the FIFO write
  always_comb begin
    dec_p0         = '0;
    dec_p0.rs1     = I_instr[19:15];
    dec_p0.rs2     = I_instr[24:20];
    dec_p0.rd      = I_instr[11:7];
    dec_p0.opcode  = I_instr[6:2];
    dec_p0.funct3  = I_instr[14:12];
    dec_p0.funct7  = I_instr[31:25];
    dec_p0.imm     = decode_imm(I_instr);
    dec_p0.pc      = I_pc;
    dec_p0.illegal = decode_illegal(I_instr);
  end

  assign O_in_ready  = (count != CW'(DEPTH));
  assign O_out_valid = (count != '0);
  assign push        = I_in_valid && O_in_ready && !I_flush;
  assign pop         = O_out_valid && I_out_ready && !I_flush;

  // FIFO control: pointers and occupancy; flush empties the queue and drops any push
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (I_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage 1: FIFO storage; cleared on reset so the head reads zero until first write
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_p1[i] <= '0;
    end else if (push) begin
      mem_p1[wr_ptr] <= dec_p0;
    end
  end

  assign head        = mem_p1[rd_ptr];
  assign O_rs1       = head.rs1;
  assign O_rs2       = head.rs2;
  assign O_rd        = head.rd;
  assign O_opcode    = head.opcode;
  assign O_funct3    = head.funct3;
  assign O_funct7    = head.funct7;
  assign O_imm       = head.imm;
  assign O_pc        = head.pc;
  assign O_illegal   = head.illegal;
  assign O_count     = count;

endmodule

// File: tb/tb_decoder_stage.sv
// Bench for decoder_stage: an RV32 and an RV64 instance driven in lockstep with the
// same stimulus; directed decode vectors plus handshake/flush/reset sequences.
module tb_decoder_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [4:0]  a_rs1, a_rs2, a_rd, a_opcode;
  logic [2:0]  a_funct3;
  logic [6:0]  a_funct7;
  logic [31:0] a_imm, a_pc;
  logic [1:0]  a_count;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [4:0]  b_rs1, b_rs2, b_rd, b_opcode;
  logic [2:0]  b_funct3;
  logic [6:0]  b_funct7;
  logic [63:0] b_imm, b_pc;
  logic [1:0]  b_count;

  int checks = 0;
  int errors = 0;

  decoder_stage #(.XLEN(32), .DEPTH(2), .CHK_ILLEGAL(1)) u32 (
    .I_clk(clk), .I_reset(rst), .I_flush(flush), .I_in_valid(in_valid),
    .O_in_ready(a_in_ready), .I_instr(instr), .I_pc(pc[31:0]),
    .O_out_valid(a_out_valid), .I_out_ready(out_ready),
    .O_rs1(a_rs1), .O_rs2(a_rs2), .O_rd(a_rd), .O_opcode(a_opcode),
    .O_funct3(a_funct3), .O_funct7(a_funct7), .O_imm(a_imm), .O_pc(a_pc),
    .O_illegal(a_illegal), .O_count(a_count)
  );

  decoder_stage #(.XLEN(64), .DEPTH(2), .CHK_ILLEGAL(1)) u64 (
    .I_clk(clk), .I_reset(rst), .I_flush(flush), .I_in_valid(in_valid),
    .O_in_ready(b_in_ready), .I_instr(instr), .I_pc(pc),
    .O_out_valid(b_out_valid), .I_out_ready(out_ready),
    .O_rs1(b_rs1), .O_rs2(b_rs2), .O_rd(b_rd), .O_opcode(b_opcode),
    .O_funct3(b_funct3), .O_funct7(b_funct7), .O_imm(b_imm), .O_pc(b_pc),
    .O_illegal(b_illegal), .O_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm64;
    logic        ill32;
    logic        ill64;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 5'd1,  5'd0,  5'd5,  5'b00100, 3'd0, 7'h00, 64'h0000000000000005, 1'b0, 1'b0};
    vecs[1]  = '{32'hFE20AE23, 5'd28, 5'd1,  5'd2,  5'b01000, 3'd2, 7'h7F, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 5'd29, 5'd0,  5'd0,  5'b11000, 3'd0, 7'h7F, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
    vecs[3]  = '{32'h800002B7, 5'd5,  5'd0,  5'd0,  5'b01101, 3'd0, 7'h40, 64'hFFFFFFFF80000000, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000001B, 5'd0,  5'd0,  5'd0,  5'b00110, 3'd0, 7'h00, 64'h0000000000000000, 1'b1, 1'b0};
    vecs[5]  = '{32'h00000000, 5'd0,  5'd0,  5'd0,  5'b00000, 3'd0, 7'h00, 64'h0000000000000000, 1'b1, 1'b1};
    vecs[6]  = '{32'h008000EF, 5'd1,  5'd0,  5'd8,  5'b11011, 3'd0, 7'h00, 64'h0000000000000008, 1'b0, 1'b0};
    vecs[7]  = '{32'hFFDFF0EF, 5'd1,  5'd31, 5'd29, 5'b11011, 3'd7, 7'h7F, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
    vecs[8]  = '{32'h00500092, 5'd1,  5'd0,  5'd5,  5'b00100, 3'd0, 7'h00, 64'h0000000000000005, 1'b1, 1'b1};
    vecs[9]  = '{32'h0000003B, 5'd0,  5'd0,  5'd0,  5'b01110, 3'd0, 7'h00, 64'h0000000000000000, 1'b1, 1'b0};
    vecs[10] = '{32'hFFF12183, 5'd3,  5'd2,  5'd31, 5'b00000, 3'd2, 7'h7F, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    vecs[11] = '{32'h12345397, 5'd7,  5'd8,  5'd3,  5'b00101, 3'd5, 7'h09, 64'h0000000012345000, 1'b0, 1'b0};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; pc = 64'h0;
    #2;
    do_reset();

    // Reset state
    check("rst_count", 64'(a_count), 64'd0);
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_imm", 64'(a_imm), 64'd0);
    check("rst_pc64", b_pc, 64'd0);
    check("rst_illegal", 64'(b_illegal), 64'd0);

    // Decode vectors: push one, check head a cycle later, pop it
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      instr = vecs[i].instr;
      pc = 64'h1000 + 64'(i) * 64'd4;
      in_valid = 1'b1;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_out_valid", i), 64'(a_out_valid), 64'd1);
      check($sformatf("v%0d_count", i), 64'(b_count), 64'd1);
      check($sformatf("v%0d_rd", i), 64'(a_rd), 64'(vecs[i].rd));
      check($sformatf("v%0d_rs1", i), 64'(a_rs1), 64'(vecs[i].rs1));
      check($sformatf("v%0d_rs2", i), 64'(b_rs2), 64'(vecs[i].rs2));
      check($sformatf("v%0d_opcode", i), 64'(a_opcode), 64'(vecs[i].opcode));
      check($sformatf("v%0d_funct3", i), 64'(a_funct3), 64'(vecs[i].f3));
      check($sformatf("v%0d_funct7", i), 64'(b_funct7), 64'(vecs[i].f7));
      check($sformatf("v%0d_imm32", i), 64'(a_imm), 64'(vecs[i].imm64[31:0]));
      check($sformatf("v%0d_imm64", i), b_imm, vecs[i].imm64);
      check($sformatf("v%0d_ill32", i), 64'(a_illegal), 64'(vecs[i].ill32));
      check($sformatf("v%0d_ill64", i), 64'(b_illegal), 64'(vecs[i].ill64));
      check($sformatf("v%0d_pc32", i), 64'(a_pc), 64'h1000 + 64'(i) * 64'd4);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("v%0d_drained", i), 64'(a_count), 64'd0);
    end

    // Back-pressure: three pushes with consumer stalled, only two accepted
    instr = 32'h00500093;
    in_valid = 1'b1;
    pc = 64'h100; step();
    check("bp_ready_after1", 64'(a_in_ready), 64'd1);
    pc = 64'h104; step();
    check("bp_ready_after2", 64'(a_in_ready), 64'd0);
    check("bp_count2", 64'(a_count), 64'd2);
    pc = 64'h108; step();
    check("bp_count_still2", 64'(b_count), 64'd2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_head0", b_pc, 64'h100);
    step();
    check("bp_head1", b_pc, 64'h104);
    check("bp_count1", 64'(a_count), 64'd1);
    step();
    check("bp_empty", 64'(a_out_valid), 64'd0);
    check("bp_ready_again", 64'(a_in_ready), 64'd1);
    out_ready = 1'b0;

    // Full FIFO with push+pop: push refused; half-full push+pop keeps count
    in_valid = 1'b1;
    pc = 64'h200; step();
    pc = 64'h204; step();
    pc = 64'h208;
    out_ready = 1'b1;
    check("full_in_ready", 64'(a_in_ready), 64'd0);
    step();
    check("full_pp_count", 64'(a_count), 64'd1);
    check("full_pp_head", b_pc, 64'h204);
    pc = 64'h20C;
    step();
    check("half_pp_count", 64'(a_count), 64'd1);
    check("half_pp_head", b_pc, 64'h20C);
    in_valid = 1'b0;
    step();
    check("half_pp_drain", 64'(a_count), 64'd0);
    out_ready = 1'b0;

    // Flush with a concurrent push: everything dropped
    in_valid = 1'b1;
    pc = 64'h300; step();
    pc = 64'h304; step();
    check("fl_pre_count", 64'(a_count), 64'd2);
    flush = 1'b1;
    pc = 64'h308;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_count", 64'(a_count), 64'd0);
    check("fl_out_valid", 64'(b_out_valid), 64'd0);
    check("fl_in_ready", 64'(a_in_ready), 64'd1);
    step();
    check("fl_stays_empty", 64'(b_count), 64'd0);

    // All-zero word after flush; head comes from slot 0 again
    instr = 32'h00000000;
    pc = 64'h400;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("zero_illegal", 64'(a_illegal), 64'd1);
    check("zero_pc", b_pc, 64'h400);

    // Asynchronous reset mid-cycle, away from any clock edge
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_count", 64'(a_count), 64'd0);
    check("arst_out_valid", 64'(b_out_valid), 64'd0);
    check("arst_imm", b_imm, 64'd0);
    rst = 1'b0;
    step();
    check("arst_hold", 64'(b_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
